// File: rtl/core_pkg.sv
// core_pkg: shared widths and the memory-stage state encoding for the
// 19-bit pipelined core.
//   DATA_W  datapath width
//   REG_W   register-index width
//   ADDR_W  data-memory address width
//   BYTE_W  width of a byte lane
package core_pkg;

  localparam int DATA_W  = 19;
  localparam int REG_W   = 5;
  localparam int ADDR_W  = 15;
  localparam int BYTE_W  = 8;
  localparam int TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: load/enable up-counter that flags when it sits on its
// terminal value. It is shared by the data and instruction memory ports to
// bound how long a bus access may wait for its acknowledge.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   load        clear the count to zero (has priority over en)
//   en          advance the count by one
//   tc          count equals TERMINAL-1
module mem_wait_timer #(
  parameter int TERMINAL = 16,
  parameter int CNT_W    = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load clears, enable increments, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/memory_stage.sv
// memory_stage: M stage of the 19-bit core. Runs loads/stores on the data
// memory bus (req/ack with timeout), stalls the pipeline while an access is
// outstanding and loads the M/W pipeline register.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   RegWriteM..Cant_ByteM           instruction in M (held while stall_m=1)
//   mem_rdata, mem_ack              memory response
//   mem_req/we/byte/addr/wdata      memory request, registered
//   stall_m                         freeze PC/F/D/E/M registers
//   mem_err                         sticky access-timeout flag
//   RegWriteW..ReadDataW            W pipeline register
module memory_stage #(
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int ADDR_W  = core_pkg::ADDR_W,
  parameter int TIMEOUT = core_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic              Cant_ByteM,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall_m,
  output logic              mem_err,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW
);

  import core_pkg::*;

  // Zero-extend the low byte lane to the full datapath width.
  function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] v);
    return {{(DATA_W-BYTE_W){1'b0}}, v[BYTE_W-1:0]};
  endfunction

  mem_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_byte_q, mem_byte_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_err_q, mem_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              result_src_w_q, result_src_w_d;
  logic [4:0]        rd_w_q, rd_w_d;
  logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_W-1:0] read_data_w_q, read_data_w_d;

  logic mem_op_s;
  logic timer_load_s;
  logic timer_en_s;
  logic timer_tc_s;

  // A load with MemWriteM also set is treated as a store.
  assign mem_op_s = MemWriteM | ResultSrcM;

  mem_wait_timer #(
    .TERMINAL (TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_s),
    .en    (timer_en_s),
    .tc    (timer_tc_s)
  );

  // Access sequencing and M/W register next-state.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_byte_d     = mem_byte_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_err_d      = mem_err_q;
    rdata_d        = rdata_q;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    rd_w_d         = rd_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    timer_load_s   = 1'b0;
    timer_en_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          state_d       = ACCESS;
          mem_req_d     = 1'b1;
          mem_we_d      = MemWriteM;
          mem_byte_d    = Cant_ByteM;
          mem_addr_d    = ALUResultM[ADDR_W-1:0];
          mem_wdata_d   = Cant_ByteM ? zext_byte(WriteDataM) : WriteDataM;
          timer_load_s  = 1'b1;
          reg_write_w_d = 1'b0;
        end else begin
          // Non-memory instruction flows straight through to W.
          reg_write_w_d  = RegWriteM;
          result_src_w_d = ResultSrcM;
          rd_w_d         = RDM;
          alu_result_w_d = ALUResultM;
          read_data_w_d  = {DATA_W{1'b0}};
        end
      end
      ACCESS: begin
        timer_en_s    = 1'b1;
        reg_write_w_d = 1'b0;
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            rdata_d = {DATA_W{1'b0}};
          end else if (mem_byte_q) begin
            rdata_d = zext_byte(mem_rdata);
          end else begin
            rdata_d = mem_rdata;
          end
        end else if (timer_tc_s) begin
          // Give up on the access; the instruction retires with zero data.
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          rdata_d   = {DATA_W{1'b0}};
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        // M still holds the memory instruction: retire it into W.
        state_d        = IDLE;
        reg_write_w_d  = RegWriteM;
        result_src_w_d = ResultSrcM;
        rd_w_d         = RDM;
        alu_result_w_d = ALUResultM;
        read_data_w_d  = rdata_q;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, bus request and W pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_byte_q     <= 1'b0;
      mem_addr_q     <= {ADDR_W{1'b0}};
      mem_wdata_q    <= {DATA_W{1'b0}};
      mem_err_q      <= 1'b0;
      rdata_q        <= {DATA_W{1'b0}};
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= 5'd0;
      alu_result_w_q <= {DATA_W{1'b0}};
      read_data_w_q  <= {DATA_W{1'b0}};
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_byte_q     <= mem_byte_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_err_q      <= mem_err_d;
      rdata_q        <= rdata_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end

  // The stall must reach the hazard unit in the same cycle the op is seen in M.
  assign stall_m = ((state_q == IDLE) && mem_op_s) || (state_q == ACCESS);

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_byte   = mem_byte_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_err    = mem_err_q;
  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign RDW        = rd_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage. The bench
// acts as upstream pipeline (holds M while stalled) and as the data memory,
// and predicts stall length, request length and W contents from the rules.
module tb_memory_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]  RDM;
  logic [18:0] WriteDataM, ALUResultM, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_byte, stall_m, mem_err;
  logic [14:0] mem_addr;
  logic [18:0] mem_wdata;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RDW;
  logic [18:0] ALUResultW, ReadDataW;

  int total = 0;
  int bad   = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RDM(RDM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM),
    .Cant_ByteM(Cant_ByteM), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_m(stall_m),
    .mem_err(mem_err), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RDW(RDW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] zext8(input logic [18:0] v);
    return {11'd0, v[7:0]};
  endfunction

  // Issue one instruction in M; delay = wait cycles before ack (>=TO: never).
  task automatic run_op(input logic rw, input logic mw, input logic rs, input logic by,
                        input logic [4:0] rd, input logic [18:0] wd, input logic [18:0] alu,
                        input int delay, input logic [18:0] rdv);
    int c;
    int stalls;
    int reqs;
    logic mem;
    logic [18:0] exp_rd;
    int exp_stall;
    int exp_req;
    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Cant_ByteM = by;
    RDM = rd; WriteDataM = wd; ALUResultM = alu; mem_ack = 1'b0;
    mem = mw | rs;
    stalls = 0; reqs = 0; c = 0;
    #1;
    while (c < 40) begin
      if (stall_m) stalls++;
      if (mem_req) reqs++;
      if (mem && c == 1) begin
        chk("addr", mem_addr, alu[14:0]);
        chk("we", mem_we, mw);
        chk("byte", mem_byte, by);
        chk("wdata", mem_wdata, by ? zext8(wd) : wd);
      end
      if (c >= 1 && stall_m) chk("bubble", RegWriteW, 1'b0);
      if (!stall_m) begin
        mem_ack = 1'($urandom_range(1));   // ack outside ACCESS must be ignored
        mem_rdata = 19'($urandom);
        break;
      end
      mem_ack = (c == delay + 1) || (c == 0 && $urandom_range(1) == 1);
      mem_rdata = (c == delay + 1) ? rdv : 19'($urandom);
      @(negedge clk);
      c++;
    end
    if (c >= 40) chk("bound", stall_m, 1'b0);
    @(posedge clk);
    #1;
    if (!mem) begin
      exp_rd = 19'd0; exp_stall = 0; exp_req = 0;
    end else if (delay < TO) begin
      exp_rd = mw ? 19'd0 : (by ? zext8(rdv) : rdv);
      exp_stall = delay + 2; exp_req = delay + 1;
    end else begin
      exp_rd = 19'd0; exp_stall = TO + 1; exp_req = TO; exp_err = 1'b1;
    end
    chk("stalls", stalls, exp_stall);
    chk("reqs", reqs, exp_req);
    chk("RegWriteW", RegWriteW, rw);
    chk("ResultSrcW", ResultSrcW, rs);
    chk("RDW", RDW, rd);
    chk("ALUResultW", ALUResultW, alu);
    chk("ReadDataW", ReadDataW, exp_rd);
    chk("mem_err", mem_err, exp_err);
    mem_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; Cant_ByteM = 1'b0;
    RDM = 5'd0; WriteDataM = 19'd0; ALUResultM = 19'd0;
    mem_rdata = 19'd0; mem_ack = 1'b0;
    #12;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", stall_m, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_addr", mem_addr, 15'd0);
    chk("rst_wdata", mem_wdata, 19'd0);
    chk("rst_W", {RegWriteW, ResultSrcW, RDW, ALUResultW, ReadDataW}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 19'd0, 19'h01234, 0, 19'd0);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 19'd0, 19'h00040, 0, 19'h7ABCD);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 19'h5A3C7, 19'h00100, 3, 19'h12345);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 19'd0, 19'h48002, 1, 19'h7FFFF);
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 19'h3FFFF, 19'h00200, 2, 19'h55555);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 19'd0, 19'h00300, 99, 19'h11111);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 19'd0, 19'h00777, 0, 19'd0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int kind;
      int dly;
      kind = int'($urandom_range(3));
      dly = ($urandom_range(19) == 0) ? 99 : int'($urandom_range(5));
      run_op(1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
             1'($urandom), 5'($urandom), 19'($urandom), 19'($urandom),
             dly, 19'($urandom));
    end

    // Reset in the middle of an access.
    @(negedge clk);
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; Cant_ByteM = 1'b0;
    RDM = 5'd6; ALUResultM = 19'h00500; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_req", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("rst2_req", mem_req, 1'b0);
    chk("rst2_err", mem_err, 1'b0);
    chk("rst2_W", {RegWriteW, ResultSrcW, RDW, ALUResultW, ReadDataW}, 32'd0);
    @(negedge clk);
    RegWriteM = 1'b0; ResultSrcM = 1'b0; RDM = 5'd0; ALUResultM = 19'd0;
    mem_ack = 1'b1; mem_rdata = 19'h7FFFF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("post_req", mem_req, 1'b0);
    chk("post_stall", stall_m, 1'b0);
    chk("post_rd", ReadDataW, 19'd0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 19'd0, 19'h00ABC, 0, 19'd0);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 19'd0, 19'h00044, 0, 19'h2468A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
